// File: rtl/bist_scheduler.sv
// ---------------------------------------------------------------------------
// bist_scheduler
//
// Sequences a logic-BIST run of NSESS sessions.  Each session seeds the
// pattern generator (INIT, 1 cycle), clocks generator and compactor for
// NCLOCK cycles (RUN), then compares the compacted signature with the golden
// value (CMP, 1 cycle).  The first mismatch ends the test early and records
// the failing session; a full set of matches ends the test with pass=1.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      begin a test (ignored while busy)
//   abort      cancel a running test (ignored in IDLE and DONE)
//   signature  MISR result from the datapath
//   golden     expected signature for session sess_idx
//   lfsr_init  load the seed for session sess_idx
//   lfsr_en    pattern generator advance enable
//   misr_en    signature compactor enable
//   sess_idx   current session number
//   busy       test in progress (INIT, RUN, CMP)
//   done       test complete, pass/fail_sess valid
//   pass       every session matched golden
//   fail_sess  first failing session (0 when pass=1)
// ---------------------------------------------------------------------------
module bist_scheduler #(
    parameter int NCLOCK = 650,
    parameter int NSESS  = 4,
    parameter int SIGW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [SIGW-1:0] signature,
    input  logic [SIGW-1:0] golden,
    output logic            lfsr_init,
    output logic            lfsr_en,
    output logic            misr_en,
    output logic [3:0]      sess_idx,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [3:0]      fail_sess
);

    localparam int CW = $clog2(NCLOCK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_CMP,
        S_DONE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    sess_n;
    logic [3:0]    fail_n;
    logic          pass_n;
    logic          last_cycle;
    logic          last_sess;
    logic          running;

    assign last_cycle = (cnt == CW'(NCLOCK - 1));
    assign last_sess  = (sess_idx == 4'(NSESS - 1));
    assign running    = (state == S_INIT) || (state == S_RUN) || (state == S_CMP);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sess_n  = sess_idx;
        fail_n  = fail_sess;
        pass_n  = pass;

        if (running && abort) begin
            // Abort outranks everything, including a simultaneous start.
            state_n = S_IDLE;
            pass_n  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_n = S_INIT;
                        sess_n  = 4'd0;
                        fail_n  = 4'd0;
                        pass_n  = 1'b0;
                    end
                end
                S_INIT: begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end
                S_RUN: begin
                    // Saturates at NCLOCK-1; the exit to CMP happens on that value.
                    if (last_cycle) state_n = S_CMP;
                    else            cnt_n   = cnt + 1'b1;
                end
                S_CMP: begin
                    if (signature == golden) begin
                        if (last_sess) begin
                            state_n = S_DONE;
                            pass_n  = 1'b1;
                        end else begin
                            state_n = S_INIT;
                            sess_n  = sess_idx + 4'd1;
                        end
                    end else begin
                        state_n = S_DONE;
                        pass_n  = 1'b0;
                        fail_n  = sess_idx;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they are glitch-free and
    // line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sess_idx  <= 4'd0;
            fail_sess <= 4'd0;
            pass      <= 1'b0;
            lfsr_init <= 1'b0;
            lfsr_en   <= 1'b0;
            misr_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sess_idx  <= sess_n;
            fail_sess <= fail_n;
            pass      <= pass_n;
            lfsr_init <= (state_n == S_INIT);
            lfsr_en   <= (state_n == S_RUN);
            misr_en   <= (state_n == S_RUN);
            busy      <= (state_n == S_INIT) || (state_n == S_RUN) || (state_n == S_CMP);
            done      <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_bist_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bist_scheduler
//
// Directed sequence with random signatures and random failing-session
// choices.  Expected timing and results come from the session arithmetic:
// a test that stops after n sessions takes n*(NCLOCK+2) cycles, issues n
// seed loads and n*NCLOCK enable cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bist_scheduler;

    localparam int NCLOCK   = 650;
    localparam int NSESS    = 4;
    localparam int SIGW     = 16;
    localparam int SESS_LEN = NCLOCK + 2;
    localparam int NO_FAIL  = 99;

    logic            clk       = 1'b0;
    logic            reset     = 1'b0;
    logic            start     = 1'b0;
    logic            abort     = 1'b0;
    logic [SIGW-1:0] signature = '0;
    logic [SIGW-1:0] golden;
    logic [SIGW-1:0] flip      = 16'h0001;
    logic            lfsr_init, lfsr_en, misr_en, busy, done, pass;
    logic [3:0]      sess_idx, fail_sess;

    int bad_sess = NO_FAIL;
    int cyc      = 0;
    int n_init   = 0;
    int n_en     = 0;
    int n_done   = 0;
    int n_bad    = 0;
    int checks   = 0;
    int failures = 0;

    bist_scheduler #(.NCLOCK(NCLOCK), .NSESS(NSESS), .SIGW(SIGW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .signature(signature), .golden(golden),
        .lfsr_init(lfsr_init), .lfsr_en(lfsr_en), .misr_en(misr_en),
        .sess_idx(sess_idx), .busy(busy), .done(done), .pass(pass),
        .fail_sess(fail_sess)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: a random signature each cycle; golden disagrees
    // only while the chosen session is being compared.
    always @(negedge clk) signature = SIGW'($urandom);
    always_comb golden = (int'(sess_idx) == bad_sess) ? (signature ^ flip) : signature;

    always @(negedge clk) begin
        if (lfsr_init) n_init <= n_init + 1;
        if (lfsr_en)   n_en   <= n_en + 1;
        if (done)      n_done <= n_done + 1;
        if ((misr_en !== lfsr_en) || (lfsr_init && lfsr_en) || (busy && done))
            n_bad <= n_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_lfsr_init"}, lfsr_init, 0);
        check({tag, "_lfsr_en"},   lfsr_en,   0);
        check({tag, "_misr_en"},   misr_en,   0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_pass"},      pass,      0);
    endtask

    // Checks the accepting edge of a start: fresh session 0, results cleared.
    task automatic check_accept(input string tag);
        check({tag, "_busy"},      busy,      1);
        check({tag, "_lfsr_init"}, lfsr_init, 1);
        check({tag, "_sess_idx"},  sess_idx,  0);
        check({tag, "_pass"},      pass,      0);
        check({tag, "_fail_sess"}, fail_sess, 0);
        check({tag, "_done"},      done,      0);
    endtask

    // Waits (bounded) for done and checks everything against the session model.
    task automatic wait_done(input string tag, input int e0, input int bi, input int be, input int b);
        int nsess;
        int exp_lat;
        int lat;
        nsess   = (b < NSESS) ? b + 1 : NSESS;
        exp_lat = nsess * SESS_LEN;
        lat     = -1;
        while (lat < 0 && (cyc - e0) <= exp_lat + 20) begin
            @(negedge clk);
            if (done) lat = cyc - e0;
        end
        @(negedge clk);
        check({tag, "_latency"},   lat, exp_lat);
        check({tag, "_pass"},      pass, (b >= NSESS) ? 1 : 0);
        check({tag, "_fail_sess"}, fail_sess, (b >= NSESS) ? 0 : b);
        check({tag, "_sess_idx"},  sess_idx, (b >= NSESS) ? NSESS - 1 : b);
        check({tag, "_n_init"},    n_init - bi, nsess);
        check({tag, "_n_en"},      n_en - be, nsess * NCLOCK);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_protocol"},  n_bad, 0);
    endtask

    // Full test: start pulse, optional stray start during RUN, wait for result.
    task automatic run_test(input string tag, input int b, input int restart_at);
        int e0, bi, be;
        bad_sess = b;
        flip     = SIGW'($urandom_range(1, 65535));
        @(negedge clk);
        bi    = n_init;
        be    = n_en;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        check_accept({tag, "_acc"});
        if (restart_at > 0) begin
            while (cyc < e0 + restart_at - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(tag, e0, bi, be, b);
    endtask

    initial begin
        int e0, bi, be, nd, b;

        // Power-on reset.
        repeat (3) @(negedge clk);
        check_quiet("reset");
        check("reset_sess_idx",  sess_idx,  0);
        check("reset_fail_sess", fail_sess, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_wait_busy", busy, 0);

        // All sessions pass.
        run_test("allpass", NO_FAIL, 0);

        // Abort while DONE has no effect.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done_done", done, 1);
        check("abort_in_done_pass", pass, 1);

        // Mismatch in session 2, then start in DONE after a failure.
        run_test("fail2", 2, 0);
        run_test("after_fail", NO_FAIL, 0);

        // Random failing sessions (NSESS means no failure).
        for (int r = 0; r < 3; r++) begin
            b = int'($urandom_range(0, NSESS));
            run_test($sformatf("rand%0d", r), b, 0);
        end

        // Stray start during RUN must not disturb the test.
        run_test("restart", NO_FAIL, 100);

        // Abort during RUN of session 0.
        bad_sess = NO_FAIL;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        while (cyc < e0 + 299) @(negedge clk);
        check("pre_abort_en", lfsr_en, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_quiet("abort");
        nd = n_done;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_no_done", n_done - nd, 0);

        // Start and abort together while idle: start wins, then abort cancels.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle_busy", busy, 1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy_idle", busy, 0);

        run_test("after_abort", NO_FAIL, 0);

        // Reset during RUN of session 1, released with start already high.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        while (cyc < e0 + 700) @(negedge clk);
        check("pre_reset_sess", sess_idx, 1);
        check("pre_reset_en",   lfsr_en,  1);
        reset = 1'b0;
        #1;
        check_quiet("async_reset");
        check("async_reset_sess", sess_idx, 0);
        repeat (3) @(negedge clk);
        check("reset_hold_en", lfsr_en, 0);
        bi    = n_init;
        be    = n_en;
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0    = cyc;
        check_accept("release_start");
        wait_done("after_reset", e0, bi, be, NO_FAIL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bist_scheduler.md
BIST_SCHEDULER -- requirements
Module: bist_scheduler

Interface
REQ-001 SHALL provide parameter NCLOCK, default 650: the number of RUN cycles per session (legal range 2..65535).
REQ-002 SHALL provide parameter NSESS, default 4: the number of test sessions per start (legal range 1..16).
REQ-003 SHALL provide parameter SIGW, default 16: the signature width in bits.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; all logic SHALL be clocked on the rising edge of clk.
REQ-005 SHALL provide port clk, input, 1 bit: system clock.
REQ-006 SHALL provide port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL provide port start, input, 1 bit: begin a test, sampled on the rising edge.
REQ-008 SHALL provide port abort, input, 1 bit: cancel the current test, sampled on the rising edge.
REQ-009 SHALL provide port signature, input, SIGW bits: MISR result from the datapath.
REQ-010 SHALL provide port golden, input, SIGW bits: expected signature for the current session.
REQ-011 SHALL provide port lfsr_init, output, 1 bit: load the seed for session sess_idx.
REQ-012 SHALL provide port lfsr_en, output, 1 bit: pattern generator advance enable.
REQ-013 SHALL provide port misr_en, output, 1 bit: signature compactor enable.
REQ-014 SHALL provide port sess_idx, output, 4 bits: current session number.
REQ-015 SHALL provide port busy, output, 1 bit: test in progress.
REQ-016 SHALL provide port done, output, 1 bit: test complete, result valid.
REQ-017 SHALL provide port pass, output, 1 bit: all sessions matched golden.
REQ-018 SHALL provide port fail_sess, output, 4 bits: index of the first failing session.

Function
REQ-019 SHALL implement an FSM with states IDLE, INIT, RUN, CMP and DONE; all outputs SHALL be registered.
REQ-020 IDLE->INIT when start=1; on this transition sess_idx SHALL be set to 0 and pass, fail_sess and done SHALL be cleared.
REQ-021 INIT SHALL last exactly 1 cycle with lfsr_init=1 and lfsr_en=misr_en=0, then go to RUN; the cycle counter SHALL clear on entry to RUN.
REQ-022 RUN SHALL last exactly NCLOCK cycles with lfsr_en=misr_en=1, then go to CMP; the counter SHALL be clog2(NCLOCK) bits and SHALL stop at NCLOCK-1, never wrapping.
REQ-023 CMP SHALL last 1 cycle with enables low and SHALL compare signature to golden.
REQ-024 On a CMP match, the FSM SHALL go to INIT with sess_idx+1 if sess_idx<NSESS-1, otherwise to DONE with pass=1.
REQ-025 On a CMP mismatch, the FSM SHALL go to DONE with pass=0 and fail_sess=sess_idx; remaining sessions SHALL be skipped.
REQ-026 A session SHALL therefore occupy NCLOCK+2 cycles; DONE SHALL be reached NSESS*(NCLOCK+2) edges after the edge that samples start when all sessions pass.
REQ-027 busy SHALL be 1 in INIT, RUN and CMP, and 0 otherwise.
REQ-028 done SHALL be 1 only in DONE; pass and fail_sess SHALL hold their values until the next accepted start.
REQ-029 DONE->INIT when start=1, as in REQ-020; there SHALL be no return to IDLE except via abort or reset.
REQ-030 start while busy=1 SHALL be ignored; no restart and no counter disturbance SHALL occur.
REQ-031 abort=1 in INIT, RUN or CMP SHALL go to IDLE on the next edge with all enables 0, done=0 and pass=0; abort SHALL have no effect in IDLE or DONE.
REQ-032 Simultaneous start and abort SHALL give abort priority when busy; when not busy, start SHALL win.
REQ-033 When fail_sess is unused (pass=1), it SHALL read 0.

Reset
REQ-034 reset=0 SHALL immediately force IDLE with lfsr_init, lfsr_en, misr_en, busy, done and pass all 0, and with sess_idx, fail_sess and the counter all 0, independent of clk.
REQ-035 Reset asserted mid-RUN SHALL drop the enables asynchronously; after release the block SHALL wait in IDLE for start.
REQ-036 Reset release SHALL take effect synchronously at the first rising edge after reset=1; start sampled at that edge SHALL be honoured.

Verification
REQ-037 Defaults, golden==signature always, start pulse at edge E0 -> lfsr_init high for 1 cycle per session, lfsr_en high for exactly 650 cycles per session (2600 total), done=1 and pass=1 from E0+2608.
REQ-038 Defaults, mismatch injected only in session 2 -> done at E0+1956, pass=0, fail_sess=2, sess_idx=2, and no lfsr_init for session 3.
REQ-039 start re-pulsed at E0+100 during RUN -> behaviour identical to REQ-037, done at E0+2608.
REQ-040 abort at E0+300 -> IDLE with all enables 0 at E0+301; done never asserts; a new start then gives the full REQ-037 sequence.
REQ-041 reset=0 asserted mid-RUN of session 1, then released, then start -> outputs 0 during reset; the subsequent run begins at sess_idx=0 and completes as in REQ-037.
REQ-042 start in DONE after a failing test -> pass and fail_sess cleared on the accepting edge; an all-match run ends with pass=1 and fail_sess=0.
